// File: rtl/alu_arbiter_pkg.sv
// Shared ALU opcode encodings and the opcode legality check.
package alu_arbiter_pkg;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_ORR   = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;
  localparam logic [3:0] ALU_PASSA = 4'b1000;

  function automatic logic is_legal_op(input logic [3:0] op);
    logic legal;
    case (op)
      ALU_AND, ALU_ORR, ALU_ADD, ALU_SUB, ALU_PASSB, ALU_PASSA: legal = 1'b1;
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between two ALU requesters, the consumer and the arbiter.
interface alu_arbiter_if #(
  parameter int unsigned N     = 64,
  parameter int unsigned CNT_W = 16
);
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [N-1:0]     req0_a;
  logic [N-1:0]     req0_b;
  logic [3:0]       req0_op;
  logic [N-1:0]     req1_a;
  logic [N-1:0]     req1_b;
  logic [3:0]       req1_op;
  logic             resp_valid;
  logic             resp_ready;
  logic             resp_id;
  logic [N-1:0]     resp_result;
  logic             resp_zero;
  logic             resp_err;
  logic [CNT_W-1:0] acc_cnt0;
  logic [CNT_W-1:0] acc_cnt1;

  // Requesters and response consumer.
  modport master (
    output req_valid, req0_a, req0_b, req0_op, req1_a, req1_b, req1_op, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_result, resp_zero, resp_err,
           acc_cnt0, acc_cnt1
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req0_a, req0_b, req0_op, req1_a, req1_b, req1_op, resp_ready,
    output req_ready, resp_valid, resp_id, resp_result, resp_zero, resp_err,
           acc_cnt0, acc_cnt1
  );
endinterface

// File: rtl/alu.sv
// Combinational ALU; undefined opcodes yield all-ones.
module alu
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned N = 64
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic [3:0]   i_op,
  output logic [N-1:0] o_result,
  output logic         o_zero
);

  // Operation decode.
  always_comb begin
    o_result = '1;
    case (i_op)
      ALU_AND:   o_result = i_a & i_b;
      ALU_ORR:   o_result = i_a | i_b;
      ALU_ADD:   o_result = i_a + i_b;
      ALU_SUB:   o_result = i_a - i_b;
      ALU_PASSB: o_result = i_b;
      ALU_PASSA: o_result = i_a;
      default:   o_result = '1;
    endcase
  end

  assign o_zero = (o_result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters, with a 1-entry
// response register and per-requester accepted-op counters.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned N     = 64,
  parameter int unsigned CNT_W = 16
) (
  input logic         clk,
  input logic         reset,
  alu_arbiter_if.slave bus
);

  logic             r_prio;
  logic             r_resp_valid;
  logic             r_resp_id;
  logic [N-1:0]     r_resp_result;
  logic             r_resp_zero;
  logic             r_resp_err;
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;

  logic [1:0]   w_grant;
  logic [1:0]   w_ready;
  logic         w_can_accept;
  logic         w_xfer;
  logic         w_id;
  logic [N-1:0] w_a;
  logic [N-1:0] w_b;
  logic [3:0]   w_op;
  logic [N-1:0] w_result;
  logic         w_zero;

  // Grant selection and operand mux; no grant while reset is asserted.
  always_comb begin
    w_grant = bus.req_valid;
    if (&bus.req_valid) w_grant = r_prio ? 2'b10 : 2'b01;
    w_can_accept = !r_resp_valid || bus.resp_ready;
    w_ready      = (reset && w_can_accept) ? w_grant : 2'b00;
    w_xfer       = |w_ready;
    w_id         = w_ready[1];
    w_a          = w_id ? bus.req1_a  : bus.req0_a;
    w_b          = w_id ? bus.req1_b  : bus.req0_b;
    w_op         = w_id ? bus.req1_op : bus.req0_op;
  end

  alu #(
    .N (N)
  ) u_alu (
    .i_a      (w_a),
    .i_b      (w_b),
    .i_op     (w_op),
    .o_result (w_result),
    .o_zero   (w_zero)
  );

  // Response register, round-robin priority and accepted-op counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_prio        <= 1'b0;
      r_resp_valid  <= 1'b0;
      r_resp_id     <= 1'b0;
      r_resp_result <= '0;
      r_resp_zero   <= 1'b0;
      r_resp_err    <= 1'b0;
      r_cnt0        <= '0;
      r_cnt1        <= '0;
    end else begin
      if (w_xfer) begin
        r_resp_valid  <= 1'b1;
        r_resp_id     <= w_id;
        r_resp_result <= w_result;
        r_resp_zero   <= w_zero;
        r_resp_err    <= !is_legal_op(w_op);
        r_prio        <= ~w_id;
        if (w_id) r_cnt1 <= r_cnt1 + CNT_W'(1);
        else      r_cnt0 <= r_cnt0 + CNT_W'(1);
      end else if (bus.resp_ready) begin
        // Drained with nothing new: data fields keep their last value.
        r_resp_valid <= 1'b0;
      end
    end
  end

  assign bus.req_ready   = w_ready;
  assign bus.resp_valid  = r_resp_valid;
  assign bus.resp_id     = r_resp_id;
  assign bus.resp_result = r_resp_result;
  assign bus.resp_zero   = r_resp_zero;
  assign bus.resp_err    = r_resp_err;
  assign bus.acc_cnt0    = r_cnt0;
  assign bus.acc_cnt1    = r_cnt1;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: opcode table plus arbitration, backpressure,
// counter wrap and mid-operation reset sequences.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_arbiter_if #(.N(64), .CNT_W(16)) bus ();

  alu_arbiter #(.N(64), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        id;
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  op;
    logic [63:0] res;
    logic        zero;
    logic        err;
  } vec_t;

  vec_t vecs [10];
  int   n_pass;
  int   n_total;
  logic        exp_prio;
  logic [15:0] exp_cnt0;
  logic [15:0] exp_cnt1;
  logic        g;
  logic        lid;
  int          m;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic set_req(input logic id, input logic [63:0] a, input logic [63:0] b,
                         input logic [3:0] op);
    if (id) begin
      bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
    end else begin
      bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
    end
  endtask

  task automatic count(input logic id);
    if (id) exp_cnt1++;
    else    exp_cnt0++;
    exp_prio = ~id;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    vecs[0] = '{1'b0, 64'd5,      64'd7,      ALU_ADD,   64'd12,                 1'b0, 1'b0};
    vecs[1] = '{1'b1, 64'd9,      64'd9,      ALU_SUB,   64'd0,                  1'b1, 1'b0};
    vecs[2] = '{1'b0, 64'hF0F0,   64'h0FF0,   ALU_AND,   64'h00F0,               1'b0, 1'b0};
    vecs[3] = '{1'b1, 64'hF000,   64'h000F,   ALU_ORR,   64'hF00F,               1'b0, 1'b0};
    vecs[4] = '{1'b0, 64'd3,      64'd5,      ALU_SUB,   64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 64'd1,      64'd0,      ALU_PASSB, 64'd0,                  1'b1, 1'b0};
    vecs[6] = '{1'b0, 64'h1234,   64'd0,      ALU_PASSA, 64'h1234,               1'b0, 1'b0};
    vecs[7] = '{1'b1, 64'd1,      64'd2,      4'b0011,   ONES,                   1'b0, 1'b1};
    vecs[8] = '{1'b0, ONES,       64'd1,      ALU_ADD,   64'd0,                  1'b1, 1'b0};
    vecs[9] = '{1'b0, 64'd4,      64'd4,      4'b1111,   ONES,                   1'b0, 1'b1};

    // Reset held two cycles with both requesters asking.
    reset = 1'b0;
    bus.resp_ready = 1'b1;
    set_req(1'b0, 64'd0, 64'd0, ALU_ADD);
    set_req(1'b1, 64'd0, 64'd0, ALU_ADD);
    bus.req_valid = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    chk("reset req_ready", 64'(bus.req_ready), 64'd0);
    chk("reset resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("reset acc_cnt0", 64'(bus.acc_cnt0), 64'd0);
    chk("reset acc_cnt1", 64'(bus.acc_cnt1), 64'd0);
    chk("reset resp_result", bus.resp_result, 64'd0);
    reset = 1'b1;
    bus.req_valid = 2'b00;
    exp_prio = 1'b0;
    exp_cnt0 = '0;
    exp_cnt1 = '0;

    // Opcode table, one requester at a time.
    foreach (vecs[i]) begin
      set_req(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].op);
      bus.req_valid = vecs[i].id ? 2'b10 : 2'b01;
      #1;
      chk("vec req_ready", 64'(bus.req_ready), vecs[i].id ? 64'd2 : 64'd1);
      @(posedge clk);
      #1;
      bus.req_valid = 2'b00;
      count(vecs[i].id);
      chk("vec resp_valid", 64'(bus.resp_valid), 64'd1);
      chk("vec resp_id", 64'(bus.resp_id), 64'(vecs[i].id));
      chk("vec resp_result", bus.resp_result, vecs[i].res);
      chk("vec resp_zero", 64'(bus.resp_zero), 64'(vecs[i].zero));
      chk("vec resp_err", 64'(bus.resp_err), 64'(vecs[i].err));
    end
    chk("table acc_cnt0", 64'(bus.acc_cnt0), 64'(exp_cnt0));
    chk("table acc_cnt1", 64'(bus.acc_cnt1), 64'(exp_cnt1));

    // Contention: both valid every cycle, grants alternate.
    set_req(1'b0, 64'd5, 64'd7, ALU_ADD);
    set_req(1'b1, 64'd9, 64'd9, ALU_SUB);
    bus.req_valid = 2'b11;
    g = exp_prio;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr req_ready", 64'(bus.req_ready), g ? 64'd2 : 64'd1);
      @(posedge clk);
      #1;
      count(g);
      chk("rr resp_valid", 64'(bus.resp_valid), 64'd1);
      chk("rr resp_id", 64'(bus.resp_id), 64'(g));
      chk("rr resp_result", bus.resp_result, g ? 64'd0 : 64'd12);
      chk("rr resp_zero", 64'(bus.resp_zero), g ? 64'd1 : 64'd0);
      g = ~g;
    end

    // Backpressure: result pending, consumer stalls three cycles.
    lid = ~g;
    bus.resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp req_ready", 64'(bus.req_ready), 64'd0);
      chk("bp resp_valid", 64'(bus.resp_valid), 64'd1);
      chk("bp resp_id", 64'(bus.resp_id), 64'(lid));
      chk("bp resp_result", bus.resp_result, lid ? 64'd0 : 64'd12);
      @(posedge clk);
    end
    #1;
    bus.resp_ready = 1'b1;
    #1;
    chk("bp drain grant", 64'(bus.req_ready), g ? 64'd2 : 64'd1);
    @(posedge clk);
    #1;
    count(g);
    chk("bp new resp_valid", 64'(bus.resp_valid), 64'd1);
    chk("bp new resp_id", 64'(bus.resp_id), 64'(g));
    bus.req_valid = 2'b00;
    @(posedge clk);
    #1;
    chk("idle drain resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("idle drain result kept", bus.resp_result, g ? 64'd0 : 64'd12);
    chk("bp acc_cnt0", 64'(bus.acc_cnt0), 64'(exp_cnt0));
    chk("bp acc_cnt1", 64'(bus.acc_cnt1), 64'(exp_cnt1));

    // Counter wrap: run requester 0 up to FFFF, then one more transfer.
    set_req(1'b0, 64'd1, 64'd1, ALU_ADD);
    bus.req_valid = 2'b01;
    m = 65535 - int'(exp_cnt0);
    repeat (m) @(posedge clk);
    #1;
    bus.req_valid = 2'b00;
    exp_cnt0 = 16'hFFFF;
    exp_prio = 1'b1;
    chk("wrap acc_cnt0 max", 64'(bus.acc_cnt0), 64'hFFFF);
    bus.req_valid = 2'b01;
    @(posedge clk);
    #1;
    bus.req_valid = 2'b00;
    chk("wrap acc_cnt0 zero", 64'(bus.acc_cnt0), 64'd0);
    chk("wrap acc_cnt1 held", 64'(bus.acc_cnt1), 64'(exp_cnt1));
    chk("wrap resp_result", bus.resp_result, 64'd2);

    // Reset while a result is pending and prio favours requester 1.
    bus.resp_ready = 1'b0;
    set_req(1'b0, 64'd5, 64'd7, ALU_ADD);
    bus.req_valid = 2'b01;
    @(posedge clk);
    #1;
    bus.req_valid = 2'b00;
    chk("midop resp_valid before", 64'(bus.resp_valid), 64'd1);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("midop resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("midop resp_result", bus.resp_result, 64'd0);
    chk("midop acc_cnt0", 64'(bus.acc_cnt0), 64'd0);
    reset = 1'b1;
    bus.resp_ready = 1'b1;
    bus.req_valid = 2'b11;
    #1;
    chk("midop prio cleared", 64'(bus.req_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 2'b00;
    chk("midop post resp_id", 64'(bus.resp_id), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
